pll_lock_supervisor: RTL
========================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before reset release (range 2..65535).
REQ-002 The block SHALL have parameter LOSS_FILTER, default 4: consecutive synchronized-unlock cycles that count as a lock loss (range 1..255).
REQ-003 The block SHALL have parameter MIN_RST_CYCLES, default 16: minimum SYS_RST_N low time after a lock loss (range 1..255).
REQ-004 The block SHALL have parameter CNT_W, default 8: width of the lock-loss counter.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock, normally a PLL global output such as GL0.
REQ-006 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port LOCK, input, 1 bit: PLL lock indicator, asynchronous to CLK.
REQ-008 The block SHALL have port CLR_CNT, input, 1 bit: synchronous clear of LOSS_CNT.
REQ-009 The block SHALL have port SYS_RST_N, output, 1 bit: registered active-low reset for the downstream logic.
REQ-010 The block SHALL have port LOCKED, output, 1 bit: high while the state is RUN.
REQ-011 The block SHALL have port LOSS_IRQ, output, 1 bit: one-cycle pulse on each detected lock loss.
REQ-012 The block SHALL have port LOSS_CNT, output, CNT_W bits: saturating count of lock losses.
REQ-013 The block SHALL have port STATE, output, 2 bits: current state, encoded WAIT_LOCK=0, STABILIZE=1, RUN=2, HOLD=3.

Function
REQ-014 LOCK SHALL pass through a two-flop synchronizer (LOCK_S); all decisions use LOCK_S only.
REQ-015 In WAIT_LOCK, the block SHALL keep SYS_RST_N=0 and clear the stability counter.
- On LOCK_S=1 it moves to STABILIZE with the counter at 0.
REQ-016 In STABILIZE, the counter SHALL increment on each cycle with LOCK_S=1.
- Any LOCK_S=0 returns the block to WAIT_LOCK with the counter cleared; no partial credit is kept.
- When LOCK_S=1 and the counter equals STABLE_CYCLES-1, the block moves to RUN.
REQ-017 SYS_RST_N and LOCKED SHALL be registered so that they change on the same edge the state enters or leaves RUN.
REQ-018 In RUN, a filter counter SHALL increment on each LOCK_S=0 cycle and clear on any LOCK_S=1 cycle.
- When LOCK_S=0 and the filter counter equals LOSS_FILTER-1, the block moves to HOLD.
- On that same edge, LOSS_IRQ pulses for exactly one cycle and LOSS_CNT increments.
REQ-019 Unlock glitches shorter than LOSS_FILTER synchronized cycles SHALL have no effect on any output.
REQ-020 In HOLD, SYS_RST_N SHALL stay 0 for exactly MIN_RST_CYCLES cycles regardless of LOCK_S, then the block moves to WAIT_LOCK.
REQ-021 LOSS_CNT SHALL saturate at all-ones and never wrap.
REQ-022 CLR_CNT=1 SHALL zero LOSS_CNT on the next edge; if a loss increment occurs in the same cycle, the clear wins and the result is 0.
REQ-023 LOSS_IRQ SHALL still pulse when LOSS_CNT is saturated or being cleared.
REQ-024 Stability, filter and hold counters SHALL be sized from their parameters and cleared on every state entry.

Reset
REQ-025 While RST_N=0, the block SHALL be in WAIT_LOCK with SYS_RST_N=0, LOCKED=0, LOSS_IRQ=0, LOSS_CNT=0, STATE=0, synchronizer flops=0 and all counters=0.
REQ-026 Reset assertion SHALL take effect immediately, without waiting for a clock edge, including mid-STABILIZE and mid-HOLD.
REQ-027 After RST_N rises, the block SHALL begin normal operation from WAIT_LOCK on the next edge.

Verification (STABLE_CYCLES=8, LOSS_FILTER=2, MIN_RST_CYCLES=4, CNT_W=8)
REQ-028 The bench SHALL cover basic lock:
- Stimulus: LOCK held at 1 from the first edge after reset.
- Response: SYS_RST_N and LOCKED rise 11 edges later; STATE sequence is 0, 1, 2.
REQ-029 The bench SHALL cover a stabilize interruption:
- Stimulus: LOCK drops for 1 cycle after 5 stable cycles, then is held at 1.
- Response: STATE returns to 0; SYS_RST_N rises 11 edges after LOCK returns high.
REQ-030 The bench SHALL cover glitch filtering:
- Stimulus: in RUN, LOCK=0 for 1 cycle.
- Response: SYS_RST_N stays 1, LOSS_IRQ stays 0, LOSS_CNT stays 0.
REQ-031 The bench SHALL cover a real lock loss:
- Stimulus: in RUN, LOCK=0 for 10 cycles, then LOCK=1.
- Response: SYS_RST_N falls 4 edges after LOCK falls; LOSS_IRQ gives a 1-cycle pulse; LOSS_CNT=1; HOLD lasts 4 cycles; re-lock follows REQ-028 timing.
REQ-032 The bench SHALL cover saturation and clear:
- Stimulus: force 256 losses, then assert CLR_CNT in the same cycle as a further loss.
- Response: LOSS_CNT reads 255 with LOSS_IRQ still pulsing, then reads 0.
REQ-033 The bench SHALL cover mid-operation reset:
- Stimulus: RST_N pulsed low during HOLD.
- Response: all outputs reach their reset values asynchronously; on release the block restarts in WAIT_LOCK.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Watches the PLL lock flag and produces a clean, registered active-low
// reset for the logic clocked by the PLL output. The reset is released only
// after the lock has been seen continuously for STABLE_CYCLES cycles. While
// running, short unlock glitches are filtered out. A real loss of lock
// reasserts the reset for at least MIN_RST_CYCLES cycles, raises a one-cycle
// interrupt and bumps a saturating loss counter.
//
// Ports
//   CLK        in   system clock (normally a PLL global output)
//   RST_N      in   asynchronous active-low reset
//   LOCK       in   PLL lock flag, asynchronous to CLK
//   CLR_CNT    in   synchronous clear of LOSS_CNT (wins over an increment)
//   SYS_RST_N  out  registered active-low reset for downstream logic
//   LOCKED     out  high while in RUN
//   LOSS_IRQ   out  one-cycle pulse on every detected lock loss
//   LOSS_CNT   out  saturating count of lock losses
//   STATE      out  current state (0 WAIT_LOCK, 1 STABILIZE, 2 RUN, 3 HOLD)
//
// state      | meaning
// -----------+------------------------------------------------------------
// WAIT_LOCK  | reset held, waiting for the synchronized lock flag
// STABILIZE  | reset held, counting consecutive locked cycles
// RUN        | reset released, filtering unlock cycles
// HOLD       | lock lost, reset held for the minimum hold time
module pll_lock_supervisor #(
   parameter int STABLE_CYCLES  = 1024,
   parameter int LOSS_FILTER    = 4,
   parameter int MIN_RST_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             LOCK,
   input  logic             CLR_CNT,
   output logic             SYS_RST_N,
   output logic             LOCKED,
   output logic             LOSS_IRQ,
   output logic [CNT_W-1:0] LOSS_CNT,
   output logic [1:0]       STATE
);

   // Each counter only has to reach its terminal value (parameter - 1).
   localparam int STAB_W = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
   localparam int FILT_W = (LOSS_FILTER    > 1) ? $clog2(LOSS_FILTER)    : 1;
   localparam int HOLD_W = (MIN_RST_CYCLES > 1) ? $clog2(MIN_RST_CYCLES) : 1;

   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_RST_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_STABILIZE = 2'd1,
      ST_RUN       = 2'd2,
      ST_HOLD      = 2'd3
   } state_t;

   logic              r_lock_meta;
   logic              r_lock_s;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [STAB_W-1:0] r_stab_cnt;
   logic [STAB_W-1:0] w_stab_cnt_nxt;
   logic [FILT_W-1:0] r_filt_cnt;
   logic [FILT_W-1:0] w_filt_cnt_nxt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_cnt_nxt;

   logic              w_loss;

   logic              r_sys_rst_n;
   logic              r_locked;
   logic              r_loss_irq;
   logic [CNT_W-1:0]  r_loss_cnt;

   // Two-flop synchronizer; nothing downstream looks at LOCK directly.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= LOCK;
         r_lock_s    <= r_lock_meta;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= ST_WAIT_LOCK;
         r_stab_cnt <= '0;
         r_filt_cnt <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_stab_cnt <= w_stab_cnt_nxt;
         r_filt_cnt <= w_filt_cnt_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
      end
   end

   // Counters default to zero, so every state transition starts them clean;
   // they only advance while the FSM stays in the state that owns them.
   always_comb begin
      w_state_nxt    = r_state;
      w_stab_cnt_nxt = '0;
      w_filt_cnt_nxt = '0;
      w_hold_cnt_nxt = '0;
      w_loss         = 1'b0;

      case (r_state)
         ST_WAIT_LOCK: begin
            if (r_lock_s) begin
               w_state_nxt = ST_STABILIZE;
            end
         end

         ST_STABILIZE: begin
            if (!r_lock_s) begin
               w_state_nxt = ST_WAIT_LOCK;
            end else if (r_stab_cnt == STAB_LAST) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_stab_cnt_nxt = r_stab_cnt + 1'b1;
            end
         end

         ST_RUN: begin
            if (!r_lock_s) begin
               if (r_filt_cnt == FILT_LAST) begin
                  w_state_nxt = ST_HOLD;
                  w_loss      = 1'b1;
               end else begin
                  w_filt_cnt_nxt = r_filt_cnt + 1'b1;
               end
            end
         end

         ST_HOLD: begin
            // Lock state is ignored here: the hold time is unconditional.
            if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = ST_WAIT_LOCK;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_WAIT_LOCK;
         end
      endcase
   end

   // Registered from the next state so the reset and LOCKED flip on the
   // same edge the FSM enters or leaves RUN.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sys_rst_n <= 1'b0;
         r_locked    <= 1'b0;
         r_loss_irq  <= 1'b0;
      end else begin
         r_sys_rst_n <= (w_state_nxt == ST_RUN);
         r_locked    <= (w_state_nxt == ST_RUN);
         r_loss_irq  <= w_loss;
      end
   end

   // Clear has priority over a coincident increment; the counter sticks at
   // all-ones instead of wrapping.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_loss_cnt <= '0;
      end else if (CLR_CNT) begin
         r_loss_cnt <= '0;
      end else if (w_loss && (r_loss_cnt != {CNT_W{1'b1}})) begin
         r_loss_cnt <= r_loss_cnt + 1'b1;
      end
   end

   assign SYS_RST_N = r_sys_rst_n;
   assign LOCKED    = r_locked;
   assign LOSS_IRQ  = r_loss_irq;
   assign LOSS_CNT  = r_loss_cnt;
   assign STATE     = r_state;

endmodule
